inv_key_schedule: RTL

Sequential round-key generator for the AES-128 decryption datapath. Accepts either the cipher key or the round-10 key and streams the eleven round keys in reverse order (round 10 first, round 0 last) over a valid/ready interface, one key per accepted transfer. It is the decrypt-side counterpart of the combinational forward key expansion. It holds only one 128-bit round key at a time instead of the full 1408-bit schedule.

---
 rtl/inv_key_schedule.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : inv_key_schedule
// Brief    : AES-128 round-key generator that streams round keys 10 down to 0
//            over valid/ready, holding a single 128-bit round key at a time.
//            128-bit values are MSB-first: bit 127 is FIPS-197 bit 0.
// Revision : 1.0 - initial release
// ============================================================================
module inv_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         key_is_last,
    input  logic [127:0] key,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] c_IDX_LAST = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic [3:0]   r_idx, w_idx_nxt;
    logic         r_valid, w_valid_nxt;
    logic         r_busy, w_busy_nxt;
    logic         r_done, w_done_nxt;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_p1, w_p2, w_p3;
    logic [31:0]  w_sub_in, w_rot, w_sub;
    logic [3:0]   w_rcon_idx;
    logic [31:0]  w_t0;
    logic [127:0] w_fwd, w_inv;

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;

    // One SubWord unit serves both directions: w3 when expanding, p3 when unwinding.
    assign w_sub_in   = (r_state == S_EMIT) ? w_p3 : w_w3;
    assign w_rot      = {w_sub_in[23:0], w_sub_in[31:24]};
    assign w_rcon_idx = (r_state == S_FWD) ? (r_idx + 4'd1) : r_idx;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign w_sub[8*g +: 8] = sbox(w_rot[8*g +: 8]);
    end

    assign w_t0 = w_w0 ^ w_sub ^ {rcon(w_rcon_idx), 24'h000000};

    assign w_fwd = {w_t0, w_t0 ^ w_w1, w_t0 ^ w_w1 ^ w_w2, w_t0 ^ w_w1 ^ w_w2 ^ w_w3};
    assign w_inv = {w_t0, w_p1, w_p2, w_p3};

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_key_nxt  = key;
                    w_busy_nxt = 1'b1;
                    if (key_is_last) begin
                        w_idx_nxt   = c_IDX_LAST;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_idx_nxt   = 4'd0;
                        w_state_nxt = S_FWD;
                    end
                end
            end
            S_FWD: begin
                w_key_nxt = w_fwd;
                w_idx_nxt = r_idx + 4'd1;
                if (r_idx == c_IDX_LAST - 4'd1) begin
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (rk_ready) begin
                    if (r_idx != 4'd0) begin
                        w_key_nxt = w_inv;
                        w_idx_nxt = r_idx - 4'd1;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_idx   <= 4'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign round_key = r_key;
    assign round_idx = r_idx;
    assign rk_valid  = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
